data_mem_ctrl: RTL and testbench

Parametrised data-memory controller for the multicycle RISC-V core, sitting between the load/store path and an internal synchronous word RAM. It accepts one byte-addressed load or store at a time through a ready/valid handshake. Stores are aligned into byte lanes and loads are extracted and sign- or zero-extended per access size. Read latency is configurable, and misaligned or out-of-range accesses complete with an error flag instead of touching memory.

---
 rtl/data_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one byte-addressed load/store at a time into a synchronous word RAM,
// with lane alignment, load sign/zero extension, configurable read latency and fault completion.
module data_mem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_ld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        state_o
);

  // Handshake: a request (read_i or write_i) is taken on a rising edge only while ready_o=1;
  // each accepted request yields exactly one single-cycle valid_o pulse, err_o qualified by it.

  localparam int         MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FAULT} state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] widx_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic [2:0]    cnt_q, cnt_d;
  logic          ram_vld_q, ram_vld_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_rdata_q;

  logic          req_c;
  logic          fault_c;
  logic [31:0]   idx_ext_c;
  logic [3:0]    be_c;
  logic [31:0]   wlane_c;
  logic [7:0]    ld_byte_c;
  logic [15:0]   ld_half_c;
  logic [31:0]   ld_fmt_c;

  assign req_c     = read_i | write_i;
  assign idx_ext_c = {{(34-ADDR_W){1'b0}}, addr_i[ADDR_W-1:2]};

  always_comb begin
    fault_c = 1'b0;
    if (size_i == 2'b11)                           fault_c = 1'b1;
    if (size_i == 2'b01 && addr_i[0])              fault_c = 1'b1;
    if (size_i == 2'b10 && addr_i[1:0] != 2'b00)   fault_c = 1'b1;
    if (idx_ext_c >= $unsigned(DEPTH))             fault_c = 1'b1;
  end

  always_comb begin
    be_c    = 4'b1111;
    wlane_c = wdata_q;
    case (size_q)
      2'b00: begin
        be_c    = 4'b0001 << off_q;
        wlane_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = off_q[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte_c = ram_rdata_q[8*off_q +: 8];
    ld_half_c = off_q[1] ? ram_rdata_q[31:16] : ram_rdata_q[15:0];
    case (size_q)
      2'b00:   ld_fmt_c = uns_q ? {24'd0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_fmt_c = uns_q ? {16'd0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_fmt_c = ram_rdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_vld_d = ram_vld_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          cnt_d     = LAT;
          ram_vld_d = 1'b0;
          if (fault_c)     state_d = FAULT;
          else if (read_i) state_d = READ;
          else             state_d = WRITE;
        end
      end
      READ: begin
        // First cycle lets the synchronous RAM produce data, then count extra wait cycles.
        if (!ram_vld_q) begin
          ram_vld_d = 1'b1;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = ld_fmt_c;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        rdata_d = 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      ram_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      widx_q    <= '0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ram_vld_q <= ram_vld_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      if (state_q == IDLE && req_c) begin
        widx_q  <= addr_i[MW+1:2];
        off_q   <= addr_i[1:0];
        size_q  <= size_i;
        uns_q   <= unsigned_ld_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Memory contents survive reset; a reset on the WRITE edge suppresses the store.
  always_ff @(posedge clk) begin
    if (state_q == WRITE && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[widx_q][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
    if (state_q == READ) ram_rdata_q <= mem[widx_q];
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (RD_LAT 1, 0, 7) with ADDR_W=13, DEPTH=1024;
// expected {err, rdata} pushed at request time and compared at the completion pulse.
module tb_data_mem_ctrl;
  localparam int AW = 13;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    rd_r, wr_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [2:0]    ready_w, valid_w, err_w;
  logic [31:0]   rdata_w [3];
  logic [1:0]    state_w [3];

  logic [32:0]   exp_q [$];
  logic [31:0]   last_rd [3];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW), .DEPTH(1024), .RD_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .read_i(rd_r[0]), .write_i(wr_r[0]), .size_i(size_r),
    .unsigned_ld_i(uns_r), .addr_i(addr_r), .wdata_i(wdata_r), .ready_o(ready_w[0]),
    .valid_o(valid_w[0]), .err_o(err_w[0]), .rdata_o(rdata_w[0]), .state_o(state_w[0]));

  data_mem_ctrl #(.ADDR_W(AW), .DEPTH(1024), .RD_LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .read_i(rd_r[1]), .write_i(wr_r[1]), .size_i(size_r),
    .unsigned_ld_i(uns_r), .addr_i(addr_r), .wdata_i(wdata_r), .ready_o(ready_w[1]),
    .valid_o(valid_w[1]), .err_o(err_w[1]), .rdata_o(rdata_w[1]), .state_o(state_w[1]));

  data_mem_ctrl #(.ADDR_W(AW), .DEPTH(1024), .RD_LAT(7)) dut_l7 (
    .clk(clk), .rst(rst), .read_i(rd_r[2]), .write_i(wr_r[2]), .size_i(size_r),
    .unsigned_ld_i(uns_r), .addr_i(addr_r), .wdata_i(wdata_r), .ready_o(ready_w[2]),
    .valid_o(valid_w[2]), .err_o(err_w[2]), .rdata_o(rdata_w[2]), .state_o(state_w[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives the request, then waits (bounded) for the completion pulse.
  task automatic req(input int inst, input logic r, input logic w, input logic [1:0] sz,
                     input logic uns, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic e_err, input logic [31:0] e_rd, input int e_lat,
                     input string tag);
    logic [32:0] exp;
    logic [31:0] rd_exp;
    int n;
    chk({tag, ":ready"}, 64'(ready_w[inst]), 64'd1);
    rd_exp = (r || e_err) ? e_rd : last_rd[inst];
    last_rd[inst] = rd_exp;
    exp_q.push_back({e_err, rd_exp});
    rd_r[inst] = r;
    wr_r[inst] = w;
    size_r = sz; uns_r = uns; addr_r = a; wdata_r = wd;
    @(posedge clk); #1;
    rd_r = 3'b000;
    wr_r = 3'b000;
    n = 0;
    while (!valid_w[inst] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, 64'(n), 64'(e_lat));
    exp = exp_q.pop_front();
    chk({tag, ":err"}, 64'(err_w[inst]), 64'(exp[32]));
    chk({tag, ":rdata"}, 64'(rdata_w[inst]), 64'(exp[31:0]));
  endtask

  initial begin
    rst = 1'b1; rd_r = 3'b000; wr_r = 3'b000;
    size_r = SW; uns_r = 1'b0; addr_r = '0; wdata_r = 32'd0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst:ready", 64'(ready_w[0]), 64'd1);
    chk("rst:valid", 64'(valid_w[0]), 64'd0);
    chk("rst:err",   64'(err_w[0]),   64'd0);
    chk("rst:rdata", 64'(rdata_w[0]), 64'd0);

    // Word store/load; each call issues in the previous completion cycle (back-to-back).
    req(0, 0, 1, SW, 0, 13'h010, 32'hDEADBEEF, 0, 0, 1, "sw_beef");
    req(0, 1, 0, SW, 0, 13'h010, 32'h0, 0, 32'hDEADBEEF, 3, "lw_beef");

    // Byte lanes and extension
    req(0, 0, 1, SW, 0, 13'h010, 32'h11223344, 0, 0, 1, "sw_1122");
    req(0, 0, 1, SB, 0, 13'h013, 32'h0000005A, 0, 0, 1, "sb_5a");
    req(0, 1, 0, SW, 0, 13'h010, 32'h0, 0, 32'h5A223344, 3, "lw_after_sb");
    req(0, 1, 0, SB, 0, 13'h013, 32'h0, 0, 32'h0000005A, 3, "lb_5a");
    req(0, 0, 1, SB, 0, 13'h011, 32'hFFFFFF80, 0, 0, 1, "sb_80");
    req(0, 1, 0, SB, 0, 13'h011, 32'h0, 0, 32'hFFFFFF80, 3, "lb_80");
    req(0, 1, 0, SB, 1, 13'h011, 32'h0, 0, 32'h00000080, 3, "lbu_80");
    req(0, 1, 0, SW, 0, 13'h010, 32'h0, 0, 32'h5A228044, 3, "lw_after_sb80");

    // Half lanes
    req(0, 0, 1, SW, 0, 13'h020, 32'h12345678, 0, 0, 1, "sw_1234");
    req(0, 0, 1, SH, 0, 13'h022, 32'h00008001, 0, 0, 1, "sh_8001");
    req(0, 1, 0, SH, 0, 13'h022, 32'h0, 0, 32'hFFFF8001, 3, "lh_8001");
    req(0, 1, 0, SH, 1, 13'h022, 32'h0, 0, 32'h00008001, 3, "lhu_8001");
    req(0, 1, 0, SH, 1, 13'h020, 32'h0, 0, 32'h00005678, 3, "lhu_low");
    req(0, 1, 0, SW, 0, 13'h020, 32'h0, 0, 32'h80015678, 3, "lw_after_sh");

    // Faults leave memory untouched; 0x1000 would alias word 0 without the range check
    req(0, 0, 1, SW, 0, 13'h004, 32'hCAFEF00D, 0, 0, 1, "sw_cafe");
    req(0, 0, 1, SW, 0, 13'h000, 32'h0BADC0DE, 0, 0, 1, "sw_bad");
    req(0, 1, 0, SW, 0, 13'h002, 32'h0, 1, 32'h0, 1, "f_lw_misal");
    req(0, 0, 1, SH, 0, 13'h005, 32'h0000FFFF, 1, 32'h0, 1, "f_sh_misal");
    req(0, 0, 1, SX, 0, 13'h020, 32'hFFFFFFFF, 1, 32'h0, 1, "f_size11");
    req(0, 1, 0, SW, 0, 13'h1000, 32'h0, 1, 32'h0, 1, "f_lw_range");
    req(0, 0, 1, SW, 0, 13'h1000, 32'hEEEEEEEE, 1, 32'h0, 1, "f_sw_range");
    req(0, 1, 0, SW, 0, 13'h004, 32'h0, 0, 32'hCAFEF00D, 3, "lw_cafe_kept");
    req(0, 1, 0, SW, 0, 13'h020, 32'h0, 0, 32'h80015678, 3, "lw_020_kept");
    req(0, 1, 0, SW, 0, 13'h000, 32'h0, 0, 32'h0BADC0DE, 3, "lw_000_kept");

    // Read wins over a simultaneous write
    req(0, 0, 1, SW, 0, 13'h030, 32'h55555555, 0, 0, 1, "sw_5555");
    req(0, 1, 1, SW, 0, 13'h030, 32'hAAAAAAAA, 0, 32'h55555555, 3, "rw_both");
    req(0, 1, 0, SW, 0, 13'h030, 32'h0, 0, 32'h55555555, 3, "lw_030_kept");

    // Read latency extremes
    req(1, 0, 1, SW, 0, 13'h040, 32'h01020304, 0, 0, 1, "l0_sw");
    req(1, 1, 0, SW, 0, 13'h040, 32'h0, 0, 32'h01020304, 2, "l0_lw");
    req(2, 0, 1, SW, 0, 13'h040, 32'hA1B2C3D4, 0, 0, 1, "l7_sw");
    req(2, 1, 0, SB, 1, 13'h042, 32'h0, 0, 32'h000000B2, 9, "l7_lbu");

    // Reset in WRITE: store dropped, no completion
    wr_r[0] = 1'b1; size_r = SW; addr_r = 13'h030; wdata_r = 32'h77777777;
    @(posedge clk); #1;
    wr_r = 3'b000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    chk("rstw:valid", 64'(valid_w[0]), 64'd0);
    chk("rstw:ready", 64'(ready_w[0]), 64'd1);
    chk("rstw:rdata", 64'(rdata_w[0]), 64'd0);
    @(posedge clk); #1;
    chk("rstw:valid_later", 64'(valid_w[0]), 64'd0);
    req(0, 1, 0, SW, 0, 13'h030, 32'h0, 0, 32'h55555555, 3, "lw_030_no_write");

    // Reset mid-READ: no completion pulse
    rd_r[0] = 1'b1; size_r = SW; addr_r = 13'h030;
    @(posedge clk); #1;
    rd_r = 3'b000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstr:valid", 64'(valid_w[0]), 64'd0);
    chk("rstr:ready", 64'(ready_w[0]), 64'd1);
    chk("rstr:rdata", 64'(rdata_w[0]), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstr:valid_later", 64'(valid_w[0]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
